// File: rtl/reg_bank_wr_16x32_pkg.sv
// rtl/reg_bank_wr_16x32_pkg.sv - shared constants and FSM encoding for the register bank write side
package reg_bank_wr_16x32_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } state_t;

endpackage

// File: rtl/reg_bank_wr_16x32_decoder_4x16.sv
// rtl/reg_bank_wr_16x32_decoder_4x16.sv - 4-to-16 one-hot decoder with enable
module decoder_4x16
    import reg_bank_wr_16x32_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_wr_16x32.sv
// rtl/reg_bank_wr_16x32.sv - write side of a 16x32 register bank with one-cycle commit and hardware scrub
module reg_bank_wr_16x32
    import reg_bank_wr_16x32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              wr_req,
    input  logic [3:0]        wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              scrub_req,
    output logic              scrub_busy,
    output logic              wr_pending,
    output logic [WIDTH-1:0]  Q0,
    output logic [WIDTH-1:0]  Q1,
    output logic [WIDTH-1:0]  Q2,
    output logic [WIDTH-1:0]  Q3,
    output logic [WIDTH-1:0]  Q4,
    output logic [WIDTH-1:0]  Q5,
    output logic [WIDTH-1:0]  Q6,
    output logic [WIDTH-1:0]  Q7,
    output logic [WIDTH-1:0]  Q8,
    output logic [WIDTH-1:0]  Q9,
    output logic [WIDTH-1:0]  Q10,
    output logic [WIDTH-1:0]  Q11,
    output logic [WIDTH-1:0]  Q12,
    output logic [WIDTH-1:0]  Q13,
    output logic [WIDTH-1:0]  Q14,
    output logic [WIDTH-1:0]  Q15
);

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic                pend_valid;
    logic [ADDR_W-1:0]   pend_addr;
    logic [WIDTH-1:0]    pend_data;
    logic                accept;
    logic [NUM_REGS-1:0] commit_en;
    logic [NUM_REGS-1:0] clear_en;
    logic                unused_en;
    wire  [WIDTH-1:0]    q [NUM_REGS];

    assign accept     = wr_req && wr_ready;
    assign wr_pending = pend_valid;

    // wr_ready and scrub_busy are kept as flops that always mirror the state
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_ready   <= 1'b1;
            scrub_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (scrub_req && !wr_req) begin
                        state      <= SCRUB;
                        cnt        <= 4'd1;
                        wr_ready   <= 1'b0;
                        scrub_busy <= 1'b1;
                    end
                end
                SCRUB: begin
                    if (cnt == 4'd15) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        wr_ready   <= 1'b1;
                        scrub_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    wr_ready   <= 1'b1;
                    scrub_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            pend_valid <= accept;
            if (accept) begin
                pend_addr <= wr_addr;
                pend_data <= wr_data;
            end
        end
    end

    decoder_4x16 u_commit_dec (
        .addr   (pend_addr),
        .en     (pend_valid),
        .onehot (commit_en)
    );

    decoder_4x16 u_clear_dec (
        .addr   (cnt),
        .en     (scrub_busy),
        .onehot (clear_en)
    );

    // Entry 0 is hard-wired, so its enables go nowhere
    assign unused_en = commit_en[0] | clear_en[0];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (k == 0) begin : g_zero
            assign q[k] = '0;
        end else begin : g_flop
            logic [WIDTH-1:0] r;
            always_ff @(posedge Clk or negedge Clr) begin
                if (!Clr) begin
                    r <= '0;
                end else if (clear_en[k]) begin
                    r <= '0;
                end else if (commit_en[k]) begin
                    r <= pend_data;
                end
            end
            assign q[k] = r;
        end
    end

    assign Q0  = q[0];
    assign Q1  = q[1];
    assign Q2  = q[2];
    assign Q3  = q[3];
    assign Q4  = q[4];
    assign Q5  = q[5];
    assign Q6  = q[6];
    assign Q7  = q[7];
    assign Q8  = q[8];
    assign Q9  = q[9];
    assign Q10 = q[10];
    assign Q11 = q[11];
    assign Q12 = q[12];
    assign Q13 = q[13];
    assign Q14 = q[14];
    assign Q15 = q[15];

endmodule

// File: tb/tb_reg_bank_wr_16x32.sv
// tb/tb_reg_bank_wr_16x32.sv - directed self-checking bench for reg_bank_wr_16x32
module tb_reg_bank_wr_16x32;

    logic        Clk;
    logic        Clr;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        scrub_req;
    logic        scrub_busy;
    logic        wr_pending;
    wire  [31:0] qv [16];
    logic [31:0] exp_q [16];
    int          checks;
    int          errors;

    reg_bank_wr_16x32 #(.WIDTH(32)) dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .scrub_req  (scrub_req),
        .scrub_busy (scrub_busy),
        .wr_pending (wr_pending),
        .Q0  (qv[0]),  .Q1  (qv[1]),  .Q2  (qv[2]),  .Q3  (qv[3]),
        .Q4  (qv[4]),  .Q5  (qv[5]),  .Q6  (qv[6]),  .Q7  (qv[7]),
        .Q8  (qv[8]),  .Q9  (qv[9]),  .Q10 (qv[10]), .Q11 (qv[11]),
        .Q12 (qv[12]), .Q13 (qv[13]), .Q14 (qv[14]), .Q15 (qv[15])
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_q%0d", tag, k), qv[k], exp_q[k]);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        Clr       = 1'b0;
        wr_req    = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 32'h0;
        scrub_req = 1'b0;
        for (int k = 0; k < 16; k++) exp_q[k] = 32'h0;

        #12;
        check_all("reset");
        chk("reset_ready", {31'b0, wr_ready}, 32'd1);
        chk("reset_busy", {31'b0, scrub_busy}, 32'd0);
        chk("reset_pending", {31'b0, wr_pending}, 32'd0);

        // reset while a write is pending
        Clr = 1'b1;
        wr_req = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
        tick();
        chk("rst_mid_pending_set", {31'b0, wr_pending}, 32'd1);
        wr_req = 1'b0;
        Clr = 1'b0;
        #1;
        chk("rst_mid_q5", qv[5], 32'h0);
        chk("rst_mid_pending", {31'b0, wr_pending}, 32'd0);
        chk("rst_mid_ready", {31'b0, wr_ready}, 32'd1);
        #1 Clr = 1'b1;
        tick();
        chk("rst_mid_q5_after", qv[5], 32'h0);
        chk("rst_mid_pending_after", {31'b0, wr_pending}, 32'd0);

        // single write
        wr_req = 1'b1; wr_addr = 4'd3; wr_data = 32'h12345678;
        tick();
        wr_req = 1'b0;
        chk("single_pending", {31'b0, wr_pending}, 32'd1);
        chk("single_q3_early", qv[3], 32'h0);
        tick();
        chk("single_pending_clr", {31'b0, wr_pending}, 32'd0);
        exp_q[3] = 32'h12345678;
        check_all("single");

        // back-to-back writes, same address then a new one
        wr_req = 1'b1; wr_addr = 4'd7; wr_data = 32'h1;
        tick();
        chk("b2b_ready0", {31'b0, wr_ready}, 32'd1);
        wr_addr = 4'd7; wr_data = 32'h2;
        tick();
        chk("b2b_ready1", {31'b0, wr_ready}, 32'd1);
        chk("b2b_q7_first", qv[7], 32'h1);
        wr_addr = 4'd8; wr_data = 32'h3;
        tick();
        chk("b2b_ready2", {31'b0, wr_ready}, 32'd1);
        wr_req = 1'b0;
        tick();
        exp_q[7] = 32'h2;
        exp_q[8] = 32'h3;
        check_all("b2b");

        // zero register is never written
        wr_req = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_req = 1'b0;
        tick();
        check_all("zero");

        // fill everything, then write 9 just before the scrub starts
        for (int k = 0; k < 16; k++) begin
            wr_req = 1'b1; wr_addr = 4'(k); wr_data = 32'hA5A5A5A5;
            tick();
            chk($sformatf("fill_ready%0d", k), {31'b0, wr_ready}, 32'd1);
            if (k != 0) exp_q[k] = 32'hA5A5A5A5;
        end
        wr_addr = 4'd9; wr_data = 32'h77;
        tick();
        wr_req = 1'b0;
        scrub_req = 1'b1;
        tick();
        exp_q[9] = 32'h77;
        check_all("scrub_entry");
        chk("scrub_entry_busy", {31'b0, scrub_busy}, 32'd1);
        chk("scrub_entry_ready", {31'b0, wr_ready}, 32'd0);

        // hold a write request through the scrub
        scrub_req = 1'b0;
        wr_req = 1'b1; wr_addr = 4'd4; wr_data = 32'h4444;
        for (int i = 1; i < 16; i++) begin
            tick();
            exp_q[i] = 32'h0;
            chk($sformatf("scrub_q%0d", i), qv[i], 32'h0);
            if (i < 15) chk($sformatf("scrub_next_q%0d", i + 1), qv[i + 1], exp_q[i + 1]);
            chk($sformatf("scrub_ready%0d", i), {31'b0, wr_ready}, (i == 15) ? 32'd1 : 32'd0);
            chk($sformatf("scrub_busy%0d", i), {31'b0, scrub_busy}, (i == 15) ? 32'd0 : 32'd1);
            chk($sformatf("scrub_pending%0d", i), {31'b0, wr_pending}, 32'd0);
        end
        check_all("scrub_done");
        tick();
        chk("post_scrub_pending", {31'b0, wr_pending}, 32'd1);
        wr_req = 1'b0;
        tick();
        exp_q[4] = 32'h4444;
        check_all("post_scrub");

        // write beats scrub in the same cycle
        wr_req = 1'b1; wr_addr = 4'd2; wr_data = 32'h22;
        scrub_req = 1'b1;
        tick();
        chk("prio_pending", {31'b0, wr_pending}, 32'd1);
        chk("prio_busy0", {31'b0, scrub_busy}, 32'd0);
        chk("prio_ready0", {31'b0, wr_ready}, 32'd1);
        wr_req = 1'b0;
        tick();
        chk("prio_busy1", {31'b0, scrub_busy}, 32'd1);
        chk("prio_ready1", {31'b0, wr_ready}, 32'd0);
        chk("prio_q2", qv[2], 32'h22);
        scrub_req = 1'b0;
        repeat (15) tick();
        for (int k = 0; k < 16; k++) exp_q[k] = 32'h0;
        check_all("prio_done");
        chk("prio_busy_end", {31'b0, scrub_busy}, 32'd0);
        chk("prio_ready_end", {31'b0, wr_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
